// File: rtl/debug_ctrl_if.sv
// UART FIFO side of the debug controller: show-ahead rx pop, tx push.
interface debug_ctrl_if;
    logic [7:0] i_rx_data;
    logic       i_rx_empty;
    logic       o_rd_uart;
    logic [7:0] o_tx_data;
    logic       o_wr_uart;
    logic       i_tx_full;

    modport master (
        input  i_rx_data, i_rx_empty, i_tx_full,
        output o_rd_uart, o_tx_data, o_wr_uart
    );

    modport slave (
        output i_rx_data, i_rx_empty, i_tx_full,
        input  o_rd_uart, o_tx_data, o_wr_uart
    );
endinterface

// File: rtl/debug_ctrl.sv
// UART debug controller: program load, run/step control, state dump.
module debug_ctrl #(
    parameter int W       = 5,
    parameter int DATA_SZ = 32,
    parameter int PC_SZ   = 32,
    parameter int INST_SZ = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    debug_ctrl_if.master       uart,
    input  logic               i_halt,
    input  logic [PC_SZ-1:0]   i_pc,
    input  logic [DATA_SZ-1:0] i_reg_data,
    input  logic [DATA_SZ-1:0] i_mem_data,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_write,
    output logic               o_enable,
    output logic [W-1:0]       o_addr
);
    typedef enum logic [2:0] {
        IDLE, LD_CNT, LD_BYTE, LD_WR,
        RUN, STEP, DUMP_SET, DUMP_SEND
    } state_t;

    localparam int CW = W + 2;
    localparam logic [CW-1:0] REGS = CW'(2 ** W);
    localparam logic [CW-1:0] LAST = CW'(2 ** (W + 1));

    state_t        state;
    logic [7:0]    cnt;
    logic [1:0]    bcnt;
    logic [CW-1:0] widx;
    logic [31:0]   shreg;
    logic [7:0]    rx;
    logic          pop;
    logic          push;
    logic          is_load;
    logic          is_run;
    logic          is_step;
    logic          is_dump;
    logic          rs;

    assign rx = uart.i_rx_data;
    assign rs = (rx == 8'h52) || (rx == 8'h53);

    assign is_load = (rx == 8'h4C);
    assign is_run  = (rx == 8'h52) && !i_halt;
    assign is_step = (rx == 8'h53) && !i_halt;
    assign is_dump = (rx == 8'h44) || (rs && i_halt);

    assign pop = i_reset && !uart.i_rx_empty &&
                 ((state == IDLE) || (state == LD_CNT) ||
                  (state == LD_BYTE));
    assign push = i_reset && !uart.i_tx_full &&
                  (state == DUMP_SEND);

    assign uart.o_rd_uart = pop;
    assign uart.o_wr_uart = push;
    assign uart.o_tx_data = shreg[31:24];

    // widx, bcnt and o_addr are zero whenever a dump starts.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bcnt          <= '0;
            widx          <= '0;
            shreg         <= '0;
            o_instruction <= '0;
            o_write       <= 1'b0;
            o_enable      <= 1'b0;
            o_addr        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        unique case (1'b1)
                            is_load: state <= LD_CNT;
                            is_run: begin
                                state    <= RUN;
                                o_enable <= 1'b1;
                            end
                            is_step: begin
                                state    <= STEP;
                                o_enable <= 1'b1;
                            end
                            is_dump: state <= DUMP_SET;
                            default: ;
                        endcase
                    end
                end
                LD_CNT: begin
                    if (pop) begin
                        cnt   <= rx;
                        bcnt  <= '0;
                        state <= (rx == 8'd0) ? IDLE : LD_BYTE;
                    end
                end
                LD_BYTE: begin
                    if (pop) begin
                        o_instruction <= {o_instruction[INST_SZ-9:0], rx};
                        bcnt          <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            o_write <= 1'b1;
                            state   <= LD_WR;
                        end
                    end
                end
                LD_WR: begin
                    o_write <= 1'b0;
                    cnt     <= cnt - 8'd1;
                    state   <= (cnt == 8'd1) ? IDLE : LD_BYTE;
                end
                RUN: begin
                    if (i_halt) begin
                        o_enable <= 1'b0;
                        state    <= DUMP_SET;
                    end
                end
                STEP: begin
                    o_enable <= 1'b0;
                    state    <= DUMP_SET;
                end
                DUMP_SET: begin
                    if (widx == '0)
                        shreg <= 32'(i_pc);
                    else if (widx <= REGS)
                        shreg <= 32'(i_reg_data);
                    else
                        shreg <= 32'(i_mem_data);
                    state <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (push) begin
                        shreg <= {shreg[23:0], 8'h00};
                        bcnt  <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            if (widx == LAST) begin
                                widx   <= '0;
                                o_addr <= '0;
                                state  <= IDLE;
                            end else begin
                                // word widx+1 reads index widx mod 2^W
                                widx   <= widx + 1'b1;
                                o_addr <= widx[W-1:0];
                                state  <= DUMP_SET;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_ctrl.sv
// Randomized bench for debug_ctrl with a FIFO/memory reference model.
module tb_debug_ctrl;
    localparam int NB = 260;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_halt;
    logic [31:0] i_pc;
    logic [31:0] i_reg_data;
    logic [31:0] i_mem_data;
    logic [31:0] o_instruction;
    logic        o_write;
    logic        o_enable;
    logic [4:0]  o_addr;

    logic [31:0] regs [32];
    logic [31:0] mems [32];

    logic [7:0]  rxq [$];
    logic [7:0]  txq [$];
    logic [31:0] wq [$];
    logic [31:0] exp_w [$];

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int en_cnt = 0;
    int viol = 0;
    int halt_at = 0;
    bit halt_hold = 0;
    bit stall = 0;

    debug_ctrl_if uart();

    debug_ctrl dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .uart         (uart.master),
        .i_halt       (i_halt),
        .i_pc         (i_pc),
        .i_reg_data   (i_reg_data),
        .i_mem_data   (i_mem_data),
        .o_instruction(o_instruction),
        .o_write      (o_write),
        .o_enable     (o_enable),
        .o_addr       (o_addr)
    );

    assign i_reg_data = regs[o_addr];
    assign i_mem_data = mems[o_addr];

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // FIFO models and event counters; sole driver of rx/tx/halt inputs.
    initial begin
        logic       rd;
        logic       wr;
        logic [7:0] txb;
        uart.i_rx_empty = 1'b1;
        uart.i_rx_data  = 8'h00;
        uart.i_tx_full  = 1'b0;
        i_halt          = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_enable) en_cnt++;
            i_halt = halt_hold || (halt_at != 0 && en_cnt >= halt_at);
            if (o_enable && o_write) viol++;
            if (uart.o_wr_uart && uart.i_tx_full) viol++;
            if (uart.o_rd_uart && uart.i_rx_empty) viol++;
            if (o_write) wq.push_back(o_instruction);
            rd  = uart.o_rd_uart;
            wr  = uart.o_wr_uart;
            txb = uart.o_tx_data;
            @(posedge i_clk);
            #1;
            if (rd && rxq.size() > 0) begin
                void'(rxq.pop_front());
                pops++;
            end
            if (wr) txq.push_back(txb);
            uart.i_tx_full  = stall ? ~uart.i_tx_full : 1'b0;
            uart.i_rx_empty = (rxq.size() == 0);
            uart.i_rx_data  = (rxq.size() == 0) ? 8'h00 : rxq[0];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    task automatic clr();
        pops = 0;
        en_cnt = 0;
        viol = 0;
        halt_at = 0;
        txq.delete();
        wq.delete();
        exp_w.delete();
    endtask

    task automatic send1(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send1(w[8*i +: 8]);
    endtask

    task automatic drain();
        int t = 0;
        while (rxq.size() != 0 && t < 400) begin
            tick(1);
            t++;
        end
        tick(4);
    endtask

    task automatic wait_tx(input int n);
        int t = 0;
        while (txq.size() < n && t < 5000) begin
            tick(1);
            t++;
        end
        check("tx_count", txq.size(), n);
    endtask

    task automatic new_state();
        i_pc = $urandom;
        for (int i = 0; i < 32; i++) begin
            regs[i] = $urandom;
            mems[i] = $urandom;
        end
    endtask

    function automatic logic [31:0] got_w(input int i);
        return (wq.size() > i) ? wq[i] : 32'hxxxxxxxx;
    endfunction

    // Expected stream: PC, then registers, then memory, 4 bytes each.
    task automatic check_dump(input string tag);
        logic [31:0] e;
        logic [31:0] g;
        for (int i = 0; i < 65; i++) begin
            e = (i == 0) ? i_pc : (i <= 32) ? regs[i-1] : mems[i-33];
            g = (txq.size() >= 4*i+4) ?
                {txq[4*i], txq[4*i+1], txq[4*i+2], txq[4*i+3]} :
                32'hxxxxxxxx;
            check($sformatf("%s_w%0d", tag, i), g, e);
        end
        check({tag, "_addr0"}, 32'(o_addr), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_instr"}, o_instruction, 32'd0);
        check({tag, "_addr"}, 32'(o_addr), 32'd0);
        check({tag, "_txd"}, 32'(uart.o_tx_data), 32'd0);
        check({tag, "_write"}, 32'(o_write), 32'd0);
        check({tag, "_enable"}, 32'(o_enable), 32'd0);
        check({tag, "_wr"}, 32'(uart.o_wr_uart), 32'd0);
    endtask

    initial begin
        int k;
        int n;
        logic [7:0] b;
        new_state();
        tick(3);
        check_zero("reset");
        check("reset_rd", 32'(uart.o_rd_uart), 32'd0);
        i_reset = 1'b1;
        tick(1);

        clr();
        send1(8'h4C); send1(8'h01); send4(32'h12345678);
        drain();
        check("load_writes", wq.size(), 1);
        check("load_word", got_w(0), 32'h12345678);
        check("load_pops", pops, 6);
        check("load_viol", viol, 0);

        for (int r = 0; r < 3; r++) begin
            clr();
            n = $urandom_range(1, 4);
            send1(8'h4C); send1(8'(n));
            for (int i = 0; i < n; i++) begin
                exp_w.push_back($urandom);
                send4(exp_w[i]);
            end
            drain();
            check("rload_writes", wq.size(), n);
            for (int i = 0; i < n; i++)
                check($sformatf("rload_w%0d", i), got_w(i), exp_w[i]);
            check("rload_pops", pops, 2 + 4*n);
        end

        clr();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            if (b == 8'h4C || b == 8'h52 || b == 8'h53 || b == 8'h44)
                b = b ^ 8'h80;
            send1(b);
        end
        drain();
        check("junk_pops", pops, 8);
        check("junk_tx", txq.size(), 0);
        check("junk_en", en_cnt, 0);
        check("junk_writes", wq.size(), 0);

        clr();
        new_state();
        send1(8'h4C); send1(8'h00); send1(8'h44);
        wait_tx(NB);
        check("ld0_writes", wq.size(), 0);
        check("ld0_pops", pops, 3);
        check_dump("ld0");

        clr();
        new_state();
        k = $urandom_range(1, 20);
        halt_at = k;
        send1(8'h52); send1(8'h00);
        wait_tx(NB);
        check("run_en", en_cnt, k);
        check("run_pops", pops, 1);
        check("run_viol", viol, 0);
        check_dump("run");
        halt_at = 0;
        drain();

        clr();
        new_state();
        send1(8'h53);
        wait_tx(NB);
        check("step_en", en_cnt, 1);
        check_dump("step");

        clr();
        new_state();
        halt_hold = 1;
        tick(2);
        send1(8'h53);
        wait_tx(NB);
        check("steph_en", en_cnt, 0);
        check_dump("steph");
        clr();
        send1(8'h52);
        wait_tx(NB);
        check("runh_en", en_cnt, 0);
        halt_hold = 0;
        tick(2);

        clr();
        new_state();
        stall = 1;
        send1(8'h44);
        wait_tx(NB);
        check_dump("stall");
        check("stall_viol", viol, 0);
        stall = 0;
        tick(2);

        clr();
        send1(8'h4C); send1(8'h01); send1(8'hAA); send1(8'hBB);
        drain();
        i_reset = 1'b0;
        tick(1);
        check_zero("rst_load");
        i_reset = 1'b1;
        clr();
        send1(8'h4C); send1(8'h01); send4(32'hAABBCCDD);
        drain();
        check("rst_load_writes", wq.size(), 1);
        check("rst_load_word", got_w(0), 32'hAABBCCDD);

        clr();
        send1(8'h52);
        tick(6);
        i_reset = 1'b0;
        tick(1);
        check("rst_run_en", 32'(o_enable), 32'd0);
        i_reset = 1'b1;

        clr();
        send1(8'h44);
        k = 0;
        while (txq.size() < 10 && k < 500) begin
            tick(1);
            k++;
        end
        i_reset = 1'b0;
        tick(1);
        check_zero("rst_dump");
        n = txq.size();
        i_reset = 1'b1;
        tick(6);
        check("rst_dump_stop", txq.size(), n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 Parameter W, default 5, address bits for register/memory debug index (2^W words each).
REQ-002 Parameter DATA_SZ, default 32, width of register/memory debug data.
REQ-003 Parameter PC_SZ, default 32, program counter width.
REQ-004 Parameter INST_SZ, default 32, instruction width.
REQ-005 i_clk  in  1  single clock; all logic on its rising edge.
REQ-006 i_reset  in  1  synchronous, active-low reset.
REQ-007 i_rx_data  in  8  head byte of UART rx FIFO (show-ahead, valid when i_rx_empty=0).
REQ-008 i_rx_empty  in  1  rx FIFO empty.
REQ-009 o_rd_uart  out  1  one-cycle pop of rx FIFO.
REQ-010 o_tx_data  out  8  byte to UART tx FIFO.
REQ-011 o_wr_uart  out  1  one-cycle push to tx FIFO.
REQ-012 i_tx_full  in  1  tx FIFO full.
REQ-013 i_halt  in  1  pipeline reached halt instruction.
REQ-014 i_pc  in  PC_SZ  current program counter.
REQ-015 i_reg_data / i_mem_data  in  DATA_SZ  register/memory word at o_addr.
REQ-016 o_instruction  out  INST_SZ  assembled instruction for loading.
REQ-017 o_write  out  1  one-cycle instruction-memory write strobe.
REQ-018 o_enable  out  1  pipeline execution enable.
REQ-019 o_addr  out  W  debug read index.

Function
REQ-020 Commands are single rx bytes: 0x4C 'L' load, 0x52 'R' run, 0x53 'S' step, 0x44 'D' dump; any other byte in IDLE is popped and discarded.
REQ-021 FSM states: IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, DUMP_SET, DUMP_SEND; IDLE pops one byte per cycle when i_rx_empty=0.
REQ-022 Every rx byte is consumed by asserting o_rd_uart for exactly one cycle while i_rx_empty=0, capturing i_rx_data that same cycle; no pop while empty.
REQ-023 'L': next byte is count N; N=0 returns to IDLE; else 4*N bytes follow, MSB-first, shifted into o_instruction.
REQ-024 After each 4th byte, LD_WR asserts o_write for exactly one cycle with the complete word stable on o_instruction, then continues to LD_BYTE or, after N words, IDLE.
REQ-025 'R': o_enable held 1 from the cycle after command capture until the first cycle i_halt=1 is sampled; o_enable drops the next cycle; then dump.
REQ-026 'S': o_enable asserted for exactly one cycle, then dump.
REQ-027 'R' or 'S' received with i_halt=1: o_enable never asserted; go directly to dump.
REQ-028 Dump order: PC, register words 0..2^W-1 (o_addr index), memory words 0..2^W-1; each word sent as 4 bytes MSB-first (PC and data zero-extended/truncated to 32 bits).
REQ-029 DUMP_SET drives o_addr and waits one cycle; word is latched from i_reg_data/i_mem_data on the following cycle.
REQ-030 o_wr_uart pulses one cycle per byte, only when i_tx_full=0; while i_tx_full=1 the FSM stalls with o_tx_data held.
REQ-031 Dump ends after 4*(1+2^(W+1)) bytes (260 for W=5); FSM returns to IDLE, o_addr returns to 0.
REQ-032 o_write and o_enable are never asserted in the same cycle; no rx byte is popped during RUN, STEP or dump.
REQ-033 o_addr index wraps from 2^W-1 to 0 when switching from registers to memory.

Reset
REQ-034 i_reset=0 at a rising edge forces IDLE and all outputs to 0 (o_instruction, o_addr, o_tx_data included), regardless of current state.
REQ-035 Reset mid-load discards the partial instruction and remaining count; reset mid-run drops o_enable the following cycle; reset mid-dump abandons remaining bytes.
REQ-036 After reset release, first action is IDLE sampling of the rx FIFO.

Verification
REQ-037 Load: rx 4C 01 12 34 56 78 -> one o_write pulse, o_instruction=0x12345678, six o_rd_uart pulses, return to IDLE.
REQ-038 Load count 0: rx 4C 00 -> no o_write; next byte 44 starts a dump.
REQ-039 Run: rx 52, i_halt rises 10 cycles later -> o_enable high exactly 10 cycles, then 260 tx bytes, first four = i_pc MSB-first.
REQ-040 Step with i_halt=0 -> o_enable one cycle then 260 bytes; step with i_halt=1 -> no o_enable, 260 bytes.
REQ-041 Dump with i_tx_full toggled every other cycle -> byte stream identical to unstalled case, no push while full.
REQ-042 Reset asserted after 2 of 4 load bytes -> outputs 0; subsequent rx 4C 01 AA BB CC DD writes 0xAABBCCDD.
